// File: rtl/deconv_pkg.sv
// rtl/deconv_pkg.sv - shared types and default widths for the deconvolution block
//
// Purpose: FSM state encoding plus the default operand/residual widths used by
// deconvolution and deconv_serdiv.
//   DW_DEF : default width of x and h
//   YW_DEF : default width of y (holds a 4-term sum of DW x DW products)
//   RW_DEF : default residual width, one sign bit plus one guard bit above YW
package deconv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DIVIDE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam int DW_DEF = 6;
  localparam int YW_DEF = 2 * DW_DEF + 2;
  localparam int RW_DEF = YW_DEF + 2;

endpackage

// File: rtl/deconv_serdiv.sv
// rtl/deconv_serdiv.sv - YW-cycle restoring divider, one quotient bit per cycle
//
// Purpose: unsigned dividend_i / divisor_i, MSB first. The first quotient bit
// is produced in the start cycle itself, so the whole division occupies exactly
// YW cycles: start_i in cycle 0, done_o in cycle YW-1. quotient_o and rem_nz_o
// are valid only while done_o is high.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start_i       begin a division (sampled only while idle)
//   dividend_i    YW-bit dividend, read in the start cycle
//   divisor_i     DW-bit divisor, must stay stable for the whole division
//   busy_o        a division is in flight after its start cycle
//   done_o        final quotient bit is being produced this cycle
//   quotient_o    full YW-bit quotient
//   rem_nz_o      final remainder is nonzero
module deconv_serdiv #(
  parameter int DW = 6,
  parameter int YW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [YW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [YW-1:0] quotient_o,
  output logic          rem_nz_o
);

  localparam int CW = $clog2(YW);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] rem_q;
  logic [YW-2:0] quo_q;
  logic [YW-1:0] dvd_q;

  logic [DW-1:0] rem_in;
  logic          bit_in;
  logic [DW:0]   trial;
  logic          ge;
  logic [DW-1:0] rem_nx;
  logic [YW-1:0] quo_nx;

  // The partial remainder is always below the divisor, so it fits in DW bits
  // and the trial subtraction can be done modulo 2^DW.
  assign rem_in = start_i ? '0 : rem_q;
  assign bit_in = start_i ? dividend_i[YW-1] : dvd_q[YW-1];
  assign trial  = {rem_in, bit_in};
  assign ge     = (trial >= {1'b0, divisor_i});
  assign rem_nx = ge ? (trial[DW-1:0] - divisor_i) : trial[DW-1:0];
  assign quo_nx = {quo_q, ge};

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CW'(YW - 1));
  assign quotient_o = quo_nx;
  assign rem_nz_o   = |rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvd_q  <= '0;
    end else if (start_i || busy_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx[YW-2:0];
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= CW'(1);
        dvd_q  <= {dividend_i[YW-2:0], 1'b0};
      end else begin
        cnt_q <= cnt_q + CW'(1);
        dvd_q <= {dvd_q[YW-2:0], 1'b0};
        if (done_o) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/deconvolution.sv
// rtl/deconvolution.sv - serial inverse of the 4-tap linear convolution unit
//
// Purpose: recovers x0..x3 from y0..y6 and taps h0..h3 by polynomial long
// division, x_k = (y_k - sum h_j*x_{k-j}) / h0, with one shared DW x DW
// multiplier and a serial divider. Optional re-convolution check of y4..y6 is
// built when DECONV_CHECK_EN is defined; otherwise err_mismatch is 0 and
// y4..y6 are ignored.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      operand handshake, in_ready high only in IDLE
//   y0..y6                   convolution outputs (YW bits, unsigned)
//   h0..h3                   kernel taps (DW bits, unsigned)
//   out_valid / out_ready    result handshake, out_valid held in DONE
//   x0..x3                   recovered inputs (DW bits, unsigned)
//   err_div0, err_inexact, err_ovf, err_neg, err_mismatch  sticky job flags
module deconvolution
  import deconv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int YW = 2 * DW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [YW-1:0] y2,
  input  logic [YW-1:0] y3,
  input  logic [YW-1:0] y4,
  input  logic [YW-1:0] y5,
  input  logic [YW-1:0] y6,
  input  logic [DW-1:0] h0,
  input  logic [DW-1:0] h1,
  input  logic [DW-1:0] h2,
  input  logic [DW-1:0] h3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x0,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3,
  output logic          err_div0,
  output logic          err_inexact,
  output logic          err_ovf,
  output logic          err_neg,
  output logic          err_mismatch
);

  localparam int RW = YW + 2;

  state_e state_q, state_d;

  logic [DW-1:0]        h_q [4];
  logic [DW-1:0]        x_q [4];
  logic [DW-1:0]        x_d [4];
  logic [YW-1:0]        y1_q, y2_q, y3_q;
  logic signed [RW-1:0] res_q, res_d;
  logic [2:0]           k_q, k_d;
  logic [2:0]           j_q, j_d;
  logic                 div0_q, div0_d;
  logic                 inexact_q, inexact_d;
  logic                 ovf_q, ovf_d;
  logic                 neg_q, neg_d;

  logic                 capture;
  logic [YW-1:0]        y_next;
  logic [1:0]           xi;
  logic [2*DW-1:0]      prod;
  logic signed [RW-1:0] mac;

  logic                 div_start, div_busy, div_done, div_rem_nz;
  logic [YW-1:0]        div_quo;

`ifdef DECONV_CHECK_EN
  logic [YW-1:0]        y4_q, y5_q, y6_q;
  logic                 mism_q, mism_d;
`else
  logic                 unused_y;
  assign unused_y = ^{y4, y5, y6};
`endif

  assign capture = in_valid && (state_q == S_IDLE);

  // Shared MAC: residual minus h_j * x_{k-j}. The x index is only meaningful
  // in ACCUM/CHECK multiply cycles, where k-j always lies in 0..3.
  assign xi   = 2'(k_q - j_q);
  assign prod = h_q[j_q[1:0]] * x_q[xi];
  assign mac  = res_q - $signed({{(RW - 2 * DW){1'b0}}, prod});

  // y operand for the step after k_q.
  always_comb begin
    y_next = '0;
    case (k_q)
      3'd0: y_next = y1_q;
      3'd1: y_next = y2_q;
      3'd2: y_next = y3_q;
`ifdef DECONV_CHECK_EN
      3'd3: y_next = y4_q;
      3'd4: y_next = y5_q;
      3'd5: y_next = y6_q;
`endif
      default: y_next = '0;
    endcase
  end

  // Residual is nonnegative whenever it is actually divided, so its low YW
  // bits are the full dividend. A zero divisor never starts the divider.
  assign div_start = (state_q == S_DIVIDE) && !div_busy && !div0_q;

  deconv_serdiv #(
    .DW(DW),
    .YW(YW)
  ) u_serdiv (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .dividend_i(res_q[YW-1:0]),
    .divisor_i (h_q[0]),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quo),
    .rem_nz_o  (div_rem_nz)
  );

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    k_d       = k_q;
    j_d       = j_q;
    x_d       = x_q;
    div0_d    = div0_q;
    inexact_d = inexact_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
`ifdef DECONV_CHECK_EN
    mism_d    = mism_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d       = '{default: '0};
          div0_d    = (h0 == '0);
          inexact_d = 1'b0;
          ovf_d     = 1'b0;
          neg_d     = 1'b0;
`ifdef DECONV_CHECK_EN
          mism_d    = 1'b0;
`endif
          res_d     = {2'b00, y0};
          k_d       = 3'd0;
          j_d       = 3'd1;
          // k=0 has no ACCUM step; a zero h0 is retired from DIVIDE.
          state_d   = S_DIVIDE;
        end
      end

      S_ACCUM: begin
        res_d = mac;
        if (j_q == k_q) begin
          state_d = S_DIVIDE;
        end else begin
          j_d = j_q + 3'd1;
        end
      end

      S_DIVIDE: begin
        if (div0_q) begin
          state_d = S_DONE;
        end else if (div_done) begin
          if (res_q[RW-1]) begin
            x_d[k_q[1:0]] = '0;
            neg_d         = 1'b1;
          end else begin
            if (|div_quo[YW-1:DW]) begin
              x_d[k_q[1:0]] = '1;
              ovf_d         = 1'b1;
            end else begin
              x_d[k_q[1:0]] = div_quo[DW-1:0];
            end
            if (div_rem_nz) begin
              inexact_d = 1'b1;
            end
          end

          if (k_q == 3'd3) begin
`ifdef DECONV_CHECK_EN
            res_d   = {2'b00, y_next};
            k_d     = 3'd4;
            j_d     = 3'd1;
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            res_d   = {2'b00, y_next};
            k_d     = k_q + 3'd1;
            j_d     = 3'd1;
            state_d = S_ACCUM;
          end
        end
      end

`ifdef DECONV_CHECK_EN
      // j_q==4 marks the compare cycle after the last MAC for this y_k.
      S_CHECK: begin
        if (j_q == 3'd4) begin
          if (res_q != '0) begin
            mism_d = 1'b1;
          end
          if (k_q == 3'd6) begin
            state_d = S_DONE;
          end else begin
            res_d = {2'b00, y_next};
            k_d   = k_q + 3'd1;
            j_d   = k_q - 3'd2;
          end
        end else begin
          res_d = mac;
          j_d   = j_q + 3'd1;
        end
      end
`endif

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      res_q     <= '0;
      k_q       <= '0;
      j_q       <= '0;
      x_q       <= '{default: '0};
      div0_q    <= 1'b0;
      inexact_q <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
`ifdef DECONV_CHECK_EN
      mism_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      k_q       <= k_d;
      j_q       <= j_d;
      x_q       <= x_d;
      div0_q    <= div0_d;
      inexact_q <= inexact_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
`ifdef DECONV_CHECK_EN
      mism_q    <= mism_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q  <= '{default: '0};
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
`ifdef DECONV_CHECK_EN
      y4_q <= '0;
      y5_q <= '0;
      y6_q <= '0;
`endif
    end else if (capture) begin
      h_q[0] <= h0;
      h_q[1] <= h1;
      h_q[2] <= h2;
      h_q[3] <= h3;
      y1_q   <= y1;
      y2_q   <= y2;
      y3_q   <= y3;
`ifdef DECONV_CHECK_EN
      y4_q   <= y4;
      y5_q   <= y5;
      y6_q   <= y6;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign x0          = x_q[0];
  assign x1          = x_q[1];
  assign x2          = x_q[2];
  assign x3          = x_q[3];
  assign err_div0    = div0_q;
  assign err_inexact = inexact_q;
  assign err_ovf     = ovf_q;
  assign err_neg     = neg_q;
`ifdef DECONV_CHECK_EN
  assign err_mismatch = mism_q;
`else
  assign err_mismatch = 1'b0;
`endif

endmodule

// File: doc/deconvolution.md
# deconvolution

Sequential inverse of the 4-tap linear convolution unit. It takes the seven convolution outputs y0..y6 and the four kernel taps h0..h3 and recovers the input vector x0..x3 by serial polynomial long division: x_k = (y_k − Σ h_j·x_{k−j}) / h0. It then re-convolves to check the result against y4..y6. It sits beside the convolution block in the accelerator datapath, behind a valid/ready handshake on both sides.

## Interface
- DW, default 6: width of x and h.
- YW, default 2*DW+2: width of y. This must hold a 4-term sum of DW×DW products.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  y/h operands valid.
- in_ready  out  1  high only in IDLE.
- y0..y6  in  YW each  convolution outputs, unsigned.
- h0..h3  in  DW each  kernel taps, unsigned.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts.
- x0..x3  out  DW each  recovered inputs, unsigned.
- err_div0, err_inexact, err_ovf, err_neg, err_mismatch  out  1 each  sticky per-job error flags.

## Operation
- **Capture.** On an edge with in_valid & in_ready, capture y and h. Clear x and all error flags.
- **States:**
  - IDLE
  - ACCUM
  - DIVIDE
  - CHECK
  - DONE
- **Divide-by-zero.** If h0==0 at capture: next state is DONE, with err_div0=1 and x=0.
- **Per x_k, k=0..3:**
  - Load the residual register (YW+2 bits, signed) with y_k.
  - ACCUM runs k cycles. Cycle j (j=1..k) subtracts h_j·x_{k−j} using the single shared DW×DW multiplier. For k=0, ACCUM is skipped.
- **DIVIDE** runs YW cycles of restoring division, one quotient bit per cycle, MSB first, of the residual by h0.
  - Residual < 0 at DIVIDE entry: x_k=0 and err_neg=1. The YW cycles are still spent, so latency stays fixed.
  - Quotient ≥ 2^DW: x_k saturates to 2^DW−1 and err_ovf=1.
  - Remainder ≠ 0: x_k = floor and err_inexact=1.
  - Later ACCUM steps use the stored (saturated or zeroed) x values.
- **CHECK**, for k=4,5,6:
  - Load y_k.
  - Subtract h_j·x_{k−j} for j=k−3..3, giving 3, 2 and 1 MAC cycles.
  - One compare cycle: a nonzero residual sets err_mismatch.
  - CHECK totals 9 cycles.
- **DONE:** out_valid=1. Transition to IDLE on out_valid & out_ready. x and the error flags keep their values until the next capture.
- **Arithmetic:** all subtraction is done in the YW+2-bit signed residual, so no wrap is possible.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - x0..x3=0
  - all err_*=0
- Reset asserted mid-operation aborts the job immediately (asynchronously). No out_valid is produced for the aborted job.
- Latency: count the accepting edge as edge 1. out_valid rises after edge 16+4·YW, which is 72 at the defaults. The budget is 1 + 6 ACCUM + 4·YW DIVIDE + 9 CHECK.
- h0==0 case: out_valid rises after edge 2.
- in_ready is low from the accepting edge until the edge that leaves DONE. A new job can be accepted on the first IDLE cycle after that.
- Outputs are registered. x and err_* are stable whenever out_valid=1.
- Holding out_ready low stalls in DONE indefinitely, with outputs unchanged.

## Configuration
- DECONV_CHECK_EN defined: the CHECK state is present and err_mismatch is live. Latency is 16+4·YW.
- DECONV_CHECK_EN undefined:
  - The CHECK state is removed; DIVIDE for x3 goes directly to DONE.
  - err_mismatch is tied to 0.
  - Latency is 7+4·YW (63 at the defaults).
  - y4..y6 are ignored.

## Structure
- Package deconv_pkg holds:
  - the state enum (IDLE, ACCUM, DIVIDE, CHECK, DONE);
  - the DW/YW default constants;
  - the residual width localparam RW = YW+2.
- Sub-module deconv_serdiv: a YW-cycle restoring divider with start/done, dividend YW bits, divisor DW bits. It returns quotient and remainder-nonzero.
- The top level holds the FSM, operand registers, the shared multiplier/accumulator and the flag logic.

## Test plan
- **Nominal:** h=(1,1,1,1), y=(1,3,6,10,9,7,4) → x=(1,2,3,4), all err=0, out_valid after edge 72.
- **Divide-by-zero:** h0=0, any y → x=(0,0,0,0), err_div0=1, out_valid after edge 2.
- **Inexact and overflow:**
  - h=(2,0,0,0), y0=5, other y=0 → x0=2, err_inexact=1, err_mismatch=0.
  - h=(1,0,0,0), y0=100 → x0=63, err_ovf=1.
- **Negative residual:** h=(1,5,0,0), y0=3, y1=2, other y=0 → x0=3, x1=0, err_neg=1.
- **Mismatch:** nominal stimulus but y6=5 → x=(1,2,3,4), err_mismatch=1. With DECONV_CHECK_EN undefined → err_mismatch=0 and out_valid after edge 63.
- **Backpressure and reset:**
  - Hold out_ready low for 10 cycles in DONE → outputs stable, in_ready=0.
  - Assert rst during DIVIDE → outputs immediately 0, in_ready=1. A subsequent nominal job completes correctly.
